flag_ctrl_unit: RTL and testbench

Sequencing controller for the 8088 FLAGS register. It accepts 3-bit flag-op commands (CLC/CMC/STC/CLD/STI/CLI/STD) over a valid/ready handshake and decodes them internally. It arbitrates those commands against ALU flag writeback, POPF/IRET loads and interrupt entry in the same cycle. It also implements the one-instruction STI interrupt shadow. It sits between the instruction decoder/ALU and the interrupt logic of the execution unit.

---
 rtl/flag_pkg.sv | 38 +++
 rtl/flag_op_dec.sv | 35 +++
 rtl/flag_ctrl_unit.sv | 150 +++++++++++++++
 tb/tb_flag_ctrl_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared constants for the 8088 FLAGS controller: opFL codes, flag bit positions,
// reserved-bit masks and the reset image.
package flag_pkg;

    localparam logic [2:0] OPF_NOP = 3'b000;
    localparam logic [2:0] OPF_CLC = 3'b001;
    localparam logic [2:0] OPF_CMC = 3'b010;
    localparam logic [2:0] OPF_STC = 3'b011;
    localparam logic [2:0] OPF_CLD = 3'b100;
    localparam logic [2:0] OPF_STI = 3'b101;
    localparam logic [2:0] OPF_CLI = 3'b110;
    localparam logic [2:0] OPF_STD = 3'b111;

    localparam int FL_CF = 0;
    localparam int FL_PF = 2;
    localparam int FL_AF = 4;
    localparam int FL_ZF = 6;
    localparam int FL_SF = 7;
    localparam int FL_TF = 8;
    localparam int FL_IF = 9;
    localparam int FL_DF = 10;
    localparam int FL_OF = 11;

    // Reserved bits 15:12 and 1 read as one, bits 3 and 5 read as zero.
    localparam logic [15:0] FLAGS_FORCE1 = 16'hF002;
    localparam logic [15:0] FLAGS_FORCE0 = 16'h0028;
    localparam logic [15:0] FLAGS_RST    = 16'hF002;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    function automatic logic [15:0] fix_reserved(input logic [15:0] f);
        return (f | FLAGS_FORCE1) & ~FLAGS_FORCE0;
    endfunction

endpackage

// File: rtl/flag_op_dec.sv
// Combinational decode of a registered opFL code into one-hot flag actions.
module flag_op_dec
    import flag_pkg::*;
(
    input  logic [2:0] op_i,
    output logic       clr_cf_o,
    output logic       clr_df_o,
    output logic       clr_if_o,
    output logic       set_cf_o,
    output logic       set_df_o,
    output logic       set_if_o,
    output logic       tog_cf_o
);

    always_comb begin
        clr_cf_o = 1'b0;
        clr_df_o = 1'b0;
        clr_if_o = 1'b0;
        set_cf_o = 1'b0;
        set_df_o = 1'b0;
        set_if_o = 1'b0;
        tog_cf_o = 1'b0;
        case (op_i)
            OPF_CLC: clr_cf_o = 1'b1;
            OPF_CMC: tog_cf_o = 1'b1;
            OPF_STC: set_cf_o = 1'b1;
            OPF_CLD: clr_df_o = 1'b1;
            OPF_STI: set_if_o = 1'b1;
            OPF_CLI: clr_if_o = 1'b1;
            OPF_STD: set_df_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/flag_ctrl_unit.sv
// FLAGS sequencing controller: flag-op handshake FSM, per-bit write arbitration,
// FLAGS register and the STI interrupt shadow (enabled by FLAG_STI_SHADOW_EN).
module flag_ctrl_unit
    import flag_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  opFL,
    output logic        op_done,
    input  logic        alu_we,
    input  logic [5:0]  alu_flags,
    input  logic [5:0]  alu_mask,
    input  logic        pop_we,
    input  logic [15:0] pop_data,
    input  logic        instr_retire,
    input  logic        int_ack,
    output logic [15:0] flags,
    output logic        irq_inhibit
);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] flags_q, flags_d;
    logic        commit;

    logic clr_cf, clr_df, clr_if, set_cf, set_df, set_if, tog_cf;

    flag_op_dec u_dec (
        .op_i     (op_q),
        .clr_cf_o (clr_cf),
        .clr_df_o (clr_df),
        .clr_if_o (clr_if),
        .set_cf_o (set_cf),
        .set_df_o (set_df),
        .set_if_o (set_if),
        .tog_cf_o (tog_cf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OPF_NOP;
            flags_q <= FLAGS_RST;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        op_ready = 1'b0;
        op_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    op_d    = opFL;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                op_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign commit = (state_q == ST_APPLY);

`ifdef FLAG_STI_SHADOW_EN
    logic pend_q, pend_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end

    assign irq_inhibit = pend_q;
`else
    logic retire_unused;
    assign retire_unused = instr_retire;
    assign irq_inhibit   = 1'b0;
`endif

    // Sources are applied lowest priority first so higher ones overwrite only their own bits.
    always_comb begin
        flags_d = flags_q;
`ifdef FLAG_STI_SHADOW_EN
        pend_d  = pend_q;
`endif
        if (alu_we) begin
            if (alu_mask[0]) flags_d[FL_CF] = alu_flags[0];
            if (alu_mask[1]) flags_d[FL_PF] = alu_flags[1];
            if (alu_mask[2]) flags_d[FL_AF] = alu_flags[2];
            if (alu_mask[3]) flags_d[FL_ZF] = alu_flags[3];
            if (alu_mask[4]) flags_d[FL_SF] = alu_flags[4];
            if (alu_mask[5]) flags_d[FL_OF] = alu_flags[5];
        end
`ifdef FLAG_STI_SHADOW_EN
        if (instr_retire && pend_q) begin
            flags_d[FL_IF] = 1'b1;
            pend_d         = 1'b0;
        end
`endif
        if (commit) begin
            if (clr_cf) flags_d[FL_CF] = 1'b0;
            if (set_cf) flags_d[FL_CF] = 1'b1;
            if (tog_cf) flags_d[FL_CF] = ~flags_q[FL_CF];
            if (clr_df) flags_d[FL_DF] = 1'b0;
            if (set_df) flags_d[FL_DF] = 1'b1;
            if (clr_if) begin
                flags_d[FL_IF] = 1'b0;
`ifdef FLAG_STI_SHADOW_EN
                pend_d = 1'b0;
`endif
            end
            if (set_if) begin
`ifdef FLAG_STI_SHADOW_EN
                // A retire in this same cycle may already have opened IF.
                if (flags_d[FL_IF]) flags_d[FL_IF] = 1'b1;
                else                pend_d         = 1'b1;
`else
                flags_d[FL_IF] = 1'b1;
`endif
            end
        end
        if (pop_we) begin
            flags_d = fix_reserved(pop_data);
`ifdef FLAG_STI_SHADOW_EN
            pend_d  = 1'b0;
`endif
        end
        if (int_ack) begin
            flags_d[FL_IF] = 1'b0;
            flags_d[FL_TF] = 1'b0;
`ifdef FLAG_STI_SHADOW_EN
            pend_d = 1'b0;
`endif
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_flag_ctrl_unit.sv
// Self-checking bench for flag_ctrl_unit: directed scenarios plus random traffic
// against a transaction-level model of the FLAGS register.
module tb_flag_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  opFL;
    logic        op_done;
    logic        alu_we;
    logic [5:0]  alu_flags;
    logic [5:0]  alu_mask;
    logic        pop_we;
    logic [15:0] pop_data;
    logic        instr_retire;
    logic        int_ack;
    logic [15:0] flags;
    logic        irq_inhibit;

    flag_ctrl_unit dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .opFL         (opFL),
        .op_done      (op_done),
        .alu_we       (alu_we),
        .alu_flags    (alu_flags),
        .alu_mask     (alu_mask),
        .pop_we       (pop_we),
        .pop_data     (pop_data),
        .instr_retire (instr_retire),
        .int_ack      (int_ack),
        .flags        (flags),
        .irq_inhibit  (irq_inhibit)
    );

    always #5 clk = ~clk;

`ifdef FLAG_STI_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'd0, CLC = 3'd1, CMC = 3'd2, STC = 3'd3;
    localparam logic [2:0] CLD = 3'd4, STI = 3'd5, CLI = 3'd6, STD = 3'd7;
    localparam int B_CF = 0, B_ZF = 6, B_TF = 8, B_IF = 9, B_DF = 10;

    int alu_pos [6] = '{0, 2, 4, 6, 7, 11};

    int n_chk = 0;
    int n_err = 0;

    // Model: architectural flags, whether an accepted op awaits commit, and the STI shadow.
    logic [15:0] m_flags;
    bit          m_busy;
    logic [2:0]  m_op;
    bit          m_pend;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = 16'hF002;
        m_busy  = 1'b0;
        m_op    = NOP;
        m_pend  = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] nf;
        bit np;
        if (rst) begin
            model_reset();
            return;
        end
        nf = m_flags;
        np = m_pend;
        if (alu_we)
            for (int i = 0; i < 6; i++)
                if (alu_mask[i]) nf[alu_pos[i]] = alu_flags[i];
        if (SHADOW && instr_retire && m_pend) begin
            nf[B_IF] = 1'b1;
            np = 1'b0;
        end
        if (m_busy) begin
            case (m_op)
                CLC: nf[B_CF] = 1'b0;
                CMC: nf[B_CF] = ~m_flags[B_CF];
                STC: nf[B_CF] = 1'b1;
                CLD: nf[B_DF] = 1'b0;
                STD: nf[B_DF] = 1'b1;
                CLI: begin nf[B_IF] = 1'b0; np = 1'b0; end
                STI: begin
                    if (!SHADOW || nf[B_IF]) nf[B_IF] = 1'b1;
                    else np = 1'b1;
                end
                default: ;
            endcase
        end
        if (pop_we) begin
            nf = pop_data | 16'hF002;
            nf[3] = 1'b0;
            nf[5] = 1'b0;
            np = 1'b0;
        end
        if (int_ack) begin
            nf[B_IF] = 1'b0;
            nf[B_TF] = 1'b0;
            np = 1'b0;
        end
        if (m_busy) m_busy = 1'b0;
        else if (op_valid) begin
            m_busy = 1'b1;
            m_op   = opFL;
        end
        m_flags = nf;
        m_pend  = np;
    endtask

    task automatic compare_outputs(input string tag);
        chk({tag, ".flags"}, 32'(flags), 32'(m_flags));
        chk({tag, ".op_ready"}, 32'(op_ready), 32'(!m_busy));
        chk({tag, ".op_done"}, 32'(op_done), 32'(m_busy));
        chk({tag, ".irq_inhibit"}, 32'(irq_inhibit), 32'(m_pend));
    endtask

    task automatic clear_inputs();
        op_valid = 1'b0; opFL = NOP;
        alu_we = 1'b0; alu_flags = '0; alu_mask = '0;
        pop_we = 1'b0; pop_data = '0;
        instr_retire = 1'b0; int_ack = 1'b0;
    endtask

    // Inputs are set at a falling edge; the model advances, the DUT clocks, outputs are compared.
    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs(tag);
        @(negedge clk);
    endtask

    task automatic issue_op(input logic [2:0] code, input string tag);
        op_valid = 1'b1;
        opFL     = code;
        cyc({tag, ".acc"});
        chk({tag, ".busy_ready"}, 32'(op_ready), 32'd0);
        chk({tag, ".busy_done"}, 32'(op_done), 32'd1);
        op_valid = 1'b0;
        opFL     = 3'($urandom_range(0, 7));
        cyc({tag, ".cmt"});
        chk({tag, ".idle_ready"}, 32'(op_ready), 32'd1);
        opFL     = NOP;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst.flags", 32'(flags), 32'hF002);
        chk("rst.op_ready", 32'(op_ready), 32'd1);
        chk("rst.op_done", 32'(op_done), 32'd0);
        chk("rst.irq_inhibit", 32'(irq_inhibit), 32'd0);
        rst = 1'b0;
        cyc("idle");

        // Asynchronous reset in the middle of APPLY discards the op.
        issue_op(STC, "stc0");
        chk("stc0.flags", 32'(flags), 32'hF003);
        op_valid = 1'b1; opFL = STD;
        cyc("std_acc");
        op_valid = 1'b0; opFL = NOP;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.flags", 32'(flags), 32'hF002);
        chk("arst.op_ready", 32'(op_ready), 32'd1);
        chk("arst.op_done", 32'(op_done), 32'd0);
        chk("arst.irq_inhibit", 32'(irq_inhibit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_arst");
        chk("post_arst.df", 32'(flags[B_DF]), 32'd0);

        // Op walk.
        issue_op(STC, "walk_stc"); chk("walk_stc.cf", 32'(flags[B_CF]), 32'd1);
        issue_op(CMC, "walk_cmc"); chk("walk_cmc.cf", 32'(flags[B_CF]), 32'd0);
        issue_op(CLC, "walk_clc"); chk("walk_clc.cf", 32'(flags[B_CF]), 32'd0);
        issue_op(STD, "walk_std"); chk("walk_std.df", 32'(flags[B_DF]), 32'd1);
        issue_op(CLD, "walk_cld"); chk("walk_cld.df", 32'(flags[B_DF]), 32'd0);
        issue_op(CLI, "walk_cli"); chk("walk_cli.if", 32'(flags[B_IF]), 32'd0);
        issue_op(NOP, "walk_nop"); chk("walk_nop.flags", 32'(flags), 32'hF002);

        // CMC against ALU CF write; ALU ZF still lands.
        issue_op(STC, "cfl_stc");
        op_valid = 1'b1; opFL = CMC;
        cyc("cfl_acc");
        op_valid = 1'b0; opFL = NOP;
        alu_we = 1'b1; alu_mask = 6'b001001; alu_flags = 6'b001001;
        cyc("cfl_cmt");
        clear_inputs();
        chk("cfl.cf", 32'(flags[B_CF]), 32'd0);
        chk("cfl.zf", 32'(flags[B_ZF]), 32'd1);

        // POPF overrides a committing STD.
        op_valid = 1'b1; opFL = STD;
        cyc("pop_acc");
        op_valid = 1'b0; opFL = NOP;
        pop_we = 1'b1; pop_data = 16'h0000;
        cyc("pop_cmt");
        clear_inputs();
        chk("pop.flags", 32'(flags), 32'hF002);
        chk("pop.df", 32'(flags[B_DF]), 32'd0);

`ifdef FLAG_STI_SHADOW_EN
        issue_op(STI, "sh_sti");
        chk("sh_sti.if", 32'(flags[B_IF]), 32'd0);
        chk("sh_sti.inh", 32'(irq_inhibit), 32'd1);
        cyc("sh_wait");
        chk("sh_wait.inh", 32'(irq_inhibit), 32'd1);
        instr_retire = 1'b1;
        cyc("sh_ret");
        instr_retire = 1'b0;
        chk("sh_ret.if", 32'(flags[B_IF]), 32'd1);
        chk("sh_ret.inh", 32'(irq_inhibit), 32'd0);

        issue_op(CLI, "sh_cli0");
        issue_op(STI, "sh_sti1");
        issue_op(CLI, "sh_cli1");
        chk("sh_cli1.inh", 32'(irq_inhibit), 32'd0);
        instr_retire = 1'b1;
        cyc("sh_ret1");
        instr_retire = 1'b0;
        chk("sh_ret1.if", 32'(flags[B_IF]), 32'd0);

        pop_we = 1'b1; pop_data = 16'h0100;
        cyc("sh_pop_tf");
        pop_we = 1'b0;
        issue_op(STI, "sh_sti2");
        chk("sh_sti2.inh", 32'(irq_inhibit), 32'd1);
        int_ack = 1'b1;
        cyc("sh_ack");
        int_ack = 1'b0;
        chk("sh_ack.if", 32'(flags[B_IF]), 32'd0);
        chk("sh_ack.tf", 32'(flags[B_TF]), 32'd0);
        chk("sh_ack.inh", 32'(irq_inhibit), 32'd0);
`else
        issue_op(STI, "nosh_sti");
        chk("nosh_sti.if", 32'(flags[B_IF]), 32'd1);
        chk("nosh_sti.inh", 32'(irq_inhibit), 32'd0);
`endif

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            op_valid     = ($urandom_range(0, 1) == 1);
            opFL         = 3'($urandom_range(0, 7));
            alu_we       = ($urandom_range(0, 9) < 3);
            alu_flags    = 6'($urandom);
            alu_mask     = 6'($urandom);
            pop_we       = ($urandom_range(0, 19) == 0);
            pop_data     = 16'($urandom);
            instr_retire = ($urandom_range(0, 9) < 3);
            int_ack      = ($urandom_range(0, 19) == 0);
            cyc($sformatf("rnd%0d", n));
        end
        rst = 1'b0;
        clear_inputs();
        cyc("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
